uart_tx_fifo: RTL and testbench

- Synthesisable, parametrised UART transmitter with a built-in transmit FIFO; successor to the fixed 8N1 async_transmitter.
- Adds configurable data width, parity mode, stop bits, a FIFO-buffered valid/ready input and a run/pause gate.
- Sits between the CPU's UART register interface and the board TXD pin.
- The simulation UART model receives its output.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is read straight from storage.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed from an internal FIFO, with a run/pause gate.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          tx_enable,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned TW  = $clog2(DIV + 1);
    localparam int unsigned IW  = 4;

    tx_state_t              state;
    tx_state_t              state_next;
    logic [TW-1:0]          timer;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [DATA_BITS-1:0]   head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   bit_done;
    logic                   can_pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE);
    assign bit_done = (timer == TW'(DIV - 1));
    assign can_pop  = !empty && tx_enable;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd        = 1'b1;
        case (state)
            IDLE: begin
                if (can_pop) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                txd = shreg[0];
                if (bit_done && bit_idx == IW'(DATA_BITS - 1))
                    state_next = (PARITY != PAR_NONE) ? PAR : STOP;
            end
            PAR: begin
                txd = par_bit;
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                // Last stop cycle chains straight into the next frame when possible.
                if (bit_done && bit_idx == IW'(STOP_BITS - 1)) begin
                    if (can_pop) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == IDLE || bit_done) timer <= '0;
            else                           timer <= timer + 1'b1;

            // Index counts bits within DATA or STOP and restarts on any state change.
            if (bit_done) begin
                if (state_next == state) bit_idx <= bit_idx + 1'b1;
                else                     bit_idx <= '0;
            end

            if (pop) begin
                shreg   <= head;
                par_bit <= (PARITY == PAR_ODD) ? ~(^head) : ^head;
            end else if (state == DATA && bit_done) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int unsigned CF  = 1_000_000;
    localparam int unsigned BR  = 100_000;
    localparam int          DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] in_data;
    logic [2:0] vld;
    logic       tx_en;
    logic [2:0] rdy;
    logic [2:0] txd;
    logic [2:0] busy;
    logic [2:0] cnt0;
    logic [3:0] cnt1;
    logic [4:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-instance FIFO ring plus position within current frame.
    int mq [3][16];
    int mhead [3];
    int mcnt [3];
    int mpos [3];
    int mcur [3];
    bit midle [3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .tx_enable(tx_en), .txd(txd[0]), .busy(busy[0]),
        .fifo_count(cnt0));

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(8)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[6:0]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .tx_enable(tx_en), .txd(txd[1]), .busy(busy[1]),
        .fifo_count(cnt1));

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .tx_enable(tx_en), .txd(txd[2]), .busy(busy[2]),
        .fifo_count(cnt2));

    function automatic int db(input int i);
        case (i) 0: return 8; 1: return 7; default: return 8; endcase
    endfunction
    function automatic int pm(input int i);
        case (i) 0: return 2; 1: return 1; default: return 0; endcase
    endfunction
    function automatic int sb(input int i);
        case (i) 0: return 1; 1: return 2; default: return 1; endcase
    endfunction
    function automatic int dp(input int i);
        case (i) 0: return 4; 1: return 8; default: return 16; endcase
    endfunction
    function automatic int flen(input int i);
        return (1 + db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i)) * DIV;
    endfunction

    function automatic int exp_txd(input int i);
        int k;
        int ones;
        if (midle[i]) return 1;
        k = mpos[i] / DIV;
        if (k == 0) return 0;
        if (k <= db(i)) return (mcur[i] >> (k - 1)) & 1;
        if (pm(i) != 0 && k == db(i) + 1) begin
            ones = $countones(mcur[i]) % 2;
            return (pm(i) == 2) ? ones : 1 - ones;
        end
        return 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mcnt[i] = 0; mhead[i] = 0; midle[i] = 1'b1; mpos[i] = 0;
            end else begin
                bit pop_ok;
                bit push_ok;
                pop_ok  = (midle[i] || mpos[i] == flen(i) - 1) && mcnt[i] > 0 && tx_en;
                push_ok = vld[i] && mcnt[i] < dp(i);
                if (push_ok) begin
                    mq[i][(mhead[i] + mcnt[i]) % dp(i)] = int'(in_data) & ((1 << db(i)) - 1);
                    mcnt[i]++;
                end
                if (pop_ok) begin
                    mcur[i]  = mq[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % dp(i);
                    mcnt[i]--;
                    midle[i] = 1'b0;
                    mpos[i]  = 0;
                end else if (!midle[i]) begin
                    if (mpos[i] == flen(i) - 1) midle[i] = 1'b1;
                    else                        mpos[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] c [3];
        c[0] = 32'(cnt0); c[1] = 32'(cnt1); c[2] = 32'(cnt2);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("txd%0d", i),   32'(txd[i]),  exp_txd(i));
            check_eq($sformatf("busy%0d", i),  32'(busy[i]), midle[i] ? 0 : 1);
            check_eq($sformatf("count%0d", i), c[i],         mcnt[i]);
            check_eq($sformatf("ready%0d", i), 32'(rdy[i]),  (mcnt[i] < dp(i)) ? 1 : 0);
        end
    endtask

    // Inputs already set; predict the post-edge state, then sample mid-cycle.
    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bit acc;
        rst = 1'b1; vld = '0; in_data = '0; tx_en = 1'b0;
        run(3);
        rst = 1'b0;
        run(2);

        // Single word 0x55 into all three transmitters.
        tx_en = 1'b1; vld = 3'b111; in_data = 9'h055;
        tick();
        vld = '0;
        for (int c = 2; c <= 130; c++) begin
            tick();
            if (c == 2 || c == 11) check_eq("p1_start", 32'(txd[2]), 0);
            if (c == 12)  check_eq("p1_bit0", 32'(txd[2]), 1);
            if (c == 22)  check_eq("p1_bit1", 32'(txd[2]), 0);
            if (c == 101) check_eq("p1_stop_busy", 32'(busy[2]), 1);
            if (c == 102) check_eq("p1_idle", 32'(busy[2]), 0);
            if (c == 95)  check_eq("p1_even_par", 32'(txd[0]), 0);
            if (c == 85)  check_eq("p1_odd_par", 32'(txd[1]), 1);
            if (c == 111) check_eq("p1_stop2_busy", 32'(busy[1]), 1);
            if (c == 112) check_eq("p1_par_idle", 32'(busy[0]), 0);
        end

        // Fill while paused, overflow u0, then release and let 0xA4 in.
        tx_en = 1'b0;
        for (int w = 0; w < 4; w++) begin
            vld = 3'b111; in_data = 9'(9'h0A0 + w);
            tick();
        end
        vld = 3'b001; in_data = 9'h0A4;
        tick();
        check_eq("p3_count_full", 32'(cnt0), 4);
        check_eq("p3_ready_low", 32'(rdy[0]), 0);
        tx_en = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = (mcnt[0] < dp(0));
            tick();
        end
        check_eq("p3_a4_accept", 32'(acc), 1);
        vld = '0;
        run(650);

        // Reset mid-frame with two words still queued.
        for (int w = 0; w < 3; w++) begin
            vld = 3'b111; in_data = 9'(9'h130 + w);
            tick();
        end
        vld = '0;
        run(34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("p5_txd", 32'(txd), 7);
        check_eq("p5_busy", 32'(busy), 0);
        check_eq("p5_cnt2", 32'(cnt2), 0);
        check_eq("p5_ready", 32'(rdy), 7);
        run(300);

        // Push on the same edge as a pop with two entries queued.
        tx_en = 1'b0;
        for (int w = 0; w < 2; w++) begin
            vld = 3'b111; in_data = 9'(9'h061 + w);
            tick();
        end
        tx_en = 1'b1; vld = 3'b111; in_data = 9'h063;
        tick();
        vld = '0;
        check_eq("p6_cnt0", 32'(cnt0), 2);
        check_eq("p6_cnt1", 32'(cnt1), 2);
        check_eq("p6_cnt2", 32'(cnt2), 2);
        run(400);

        // Random traffic with pauses and occasional resets.
        for (int k = 0; k < 8000; k++) begin
            for (int i = 0; i < 3; i++) vld[i] = ($urandom_range(0, 59) == 0);
            in_data = 9'($urandom);
            if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0; vld = '0; tx_en = 1'b1;
        run(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
